// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and memory-wait states.
package hazard_ctrl_unit_pkg;
   localparam int REG_ID_W_DEFAULT = 6;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      MW_IDLE = 1'b0,
      MW_WAIT = 1'b1
   } mem_wait_state_t;
endpackage

// File: rtl/hazard_ctrl_unit_mem_wait_fsm.sv
// Data-memory wait sequencer: stalls the pipeline for MEM_LAT-1 cycles per access,
// plus one cycle for every cycle mem_ready stays low once the minimum latency is met.
module mem_wait_fsm
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_access,
   input  logic mem_ready,
   output logic mem_stall
);
   localparam int CNT_BITS = $clog2(MEM_LAT) + 1;
   localparam bit MULTI_CYCLE = (MEM_LAT > 1);
   // The entry cycle is the first access cycle, so WAIT starts one count below MEM_LAT-1.
   localparam logic [CNT_BITS-1:0] CNT_LOAD = MULTI_CYCLE ? CNT_BITS'(MEM_LAT - 2) : '0;

   mem_wait_state_t       state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      case (state_q)
         MW_IDLE: begin
            if (mem_access && (MULTI_CYCLE || !mem_ready)) begin
               state_d   = MW_WAIT;
               cnt_d     = CNT_LOAD;
               mem_stall = 1'b1;
            end
         end
         MW_WAIT: begin
            if ((cnt_q == '0) && mem_ready) begin
               state_d = MW_IDLE;
            end else begin
               mem_stall = 1'b1;
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_BITS'(1);
               end
            end
         end
         default: state_d = MW_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MW_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: EX forwarding, load-use bubble, branch flush, memory-wait stall.
// Optional perf counters (stall_cycles, flush_count) built only with HAZ_PERF_CNT_EN defined.
module hazard_ctrl_unit
   import hazard_ctrl_unit_pkg::*;
#(
   parameter int REG_ID_W = REG_ID_W_DEFAULT,
   parameter int MEM_LAT  = 1
`ifdef HAZ_PERF_CNT_EN
   ,
   parameter int CNT_W    = 32
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [REG_ID_W-1:0] id_rs1,
   input  logic [REG_ID_W-1:0] id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [REG_ID_W-1:0] ex_rs1,
   input  logic [REG_ID_W-1:0] ex_rs2,
   input  logic [REG_ID_W-1:0] ex_rd,
   input  logic                ex_mem_read,
   input  logic                branch_taken,
   input  logic [REG_ID_W-1:0] mem_rd,
   input  logic                mem_reg_write,
   input  logic                mem_access,
   input  logic                mem_ready,
   input  logic [REG_ID_W-1:0] wb_rd,
   input  logic                wb_reg_write,
   output fwd_sel_t            forward_a,
   output fwd_sel_t            forward_b,
   output logic                pc_write,
   output logic                if_id_write,
   output logic                id_ex_write,
   output logic                ex_mem_write,
   output logic                if_id_flush,
   output logic                id_ex_flush,
   output logic                mem_wb_bubble
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    stall_cycles,
   output logic [CNT_W-1:0]    flush_count
`endif
);
   logic     mem_stall;
   logic     load_use;
   fwd_sel_t fwd_a, fwd_b;

   mem_wait_fsm #(.MEM_LAT(MEM_LAT)) u_mem_wait (
      .clk        (clk),
      .reset      (reset),
      .mem_access (mem_access),
      .mem_ready  (mem_ready),
      .mem_stall  (mem_stall)
   );

   always_comb begin
      fwd_a = FWD_RF;
      if (ex_rs1 != '0 && mem_reg_write && mem_rd == ex_rs1)     fwd_a = FWD_MEM;
      else if (ex_rs1 != '0 && wb_reg_write && wb_rd == ex_rs1)  fwd_a = FWD_WB;
      fwd_b = FWD_RF;
      if (ex_rs2 != '0 && mem_reg_write && mem_rd == ex_rs2)     fwd_b = FWD_MEM;
      else if (ex_rs2 != '0 && wb_reg_write && wb_rd == ex_rs2)  fwd_b = FWD_WB;

      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));

      forward_a     = FWD_RF;
      forward_b     = FWD_RF;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      ex_mem_write  = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      mem_wb_bubble = 1'b0;

      // EX is frozen during a memory stall, so branch/load-use wait for its release.
      if (!reset) begin
         forward_a = fwd_a;
         forward_b = fwd_b;
         if (mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
         end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] flush_count_q, flush_count_d;

   // pc_write drops only for a memory stall or a load-use bubble; if_id_flush only for a branch.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (!pc_write && stall_cycles_q != '1) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (if_id_flush && flush_count_q != '1) flush_count_d = flush_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif
endmodule
